// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flip-flop, LSB first, start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             load;
    logic             last;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic             s;
    logic             c_next;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign s        = a_sh[0] ^ b_sh[0] ^ carry;
    assign c_next   = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    // Shifting the new bit in at the MSB leaves bit 0 in place after WIDTH steps.
    assign res_next = (res_sh >> 1) | (WIDTH'(s) << (WIDTH - 1));
    assign busy     = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            done   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (load) begin
                a_sh   <= a;
                b_sh   <= b;
                res_sh <= '0;
                carry  <= cin;
                cnt    <= '0;
            end else if (state == RUN) begin
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                res_sh <= res_next;
                carry  <= c_next;
                cnt    <= cnt + 1'b1;
                if (last) begin
                    sum  <= res_next;
                    cout <= c_next;
                    done <= 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry still holds the carry into the MSB on this edge
                    ovf  <= carry ^ c_next;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8), with extra ovf checks
// when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
    logic             done;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] prev_sum;
    logic             prev_cout;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives a start request and checks the cycle right after the accepting edge.
    task automatic begin_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("done_after_start", 32'(done), 32'd0);
    endtask

    task automatic wait_bits(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check("busy_in_run", 32'(busy), 32'd1);
            check("done_in_run", 32'(done), 32'd0);
            check("sum_holds", 32'(sum), 32'(prev_sum));
            check("cout_holds", 32'(cout), 32'(prev_cout));
        end
    endtask

    task automatic finish_op(input string tag, input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
        tick();
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
        prev_sum  = exp_sum;
        prev_cout = exp_cout;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b1;
        a         = 8'hAA;
        b         = 8'h55;
        cin       = 1'b1;
        prev_sum  = '0;
        prev_cout = 1'b0;

        tick();
        tick();
        check("rst_sum", 32'(sum), 32'h00);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);

        // Basic add
        begin_op(8'h05, 8'h03, 1'b0);
        wait_bits(WIDTH - 1);
        finish_op("basic", 8'h08, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
        check("basic_ovf", 32'(ovf), 32'd0);
`endif
        tick();
        check("done_one_cycle", 32'(done), 32'd0);

        // Carry boundaries, second one started in the done cycle of the first
        begin_op(8'hFF, 8'h01, 1'b0);
        wait_bits(WIDTH - 1);
        finish_op("ff_p_01", 8'h00, 1'b1);
        begin_op(8'hFF, 8'hFF, 1'b1);
        wait_bits(WIDTH - 1);
        finish_op("ff_p_ff_c", 8'hFF, 1'b1);
`ifdef SERIAL_ADDER_OVF_EN
        check("ff_p_ff_c_ovf", 32'(ovf), 32'd0);
`endif
        begin_op(8'h00, 8'h00, 1'b1);
        wait_bits(WIDTH - 1);
        finish_op("zero_cin", 8'h01, 1'b0);

        // Start pulsed mid-run must be ignored
        begin_op(8'h10, 8'h20, 1'b0);
        wait_bits(2);
        a     = 8'hF0;
        b     = 8'hF0;
        start = 1'b1;
        wait_bits(1);
        start = 1'b0;
        wait_bits(WIDTH - 4);
        finish_op("ignore_start", 8'h30, 1'b0);
        tick();
        check("no_restart_busy", 32'(busy), 32'd0);

        // Reset in the middle of an operation
        begin_op(8'h7F, 8'h01, 1'b0);
        wait_bits(4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sum", 32'(sum), 32'h00);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        prev_sum  = '0;
        prev_cout = 1'b0;
        tick();
        check("abort_no_done", 32'(done), 32'd0);

        begin_op(8'h7F, 8'h01, 1'b0);
        wait_bits(WIDTH - 1);
        finish_op("7f_p_01", 8'h80, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
        check("7f_p_01_ovf", 32'(ovf), 32'd1);
`endif
        begin_op(8'h80, 8'h80, 1'b0);
        wait_bits(WIDTH - 1);
        finish_op("80_p_80", 8'h00, 1'b1);
`ifdef SERIAL_ADDER_OVF_EN
        check("80_p_80_ovf", 32'(ovf), 32'd1);
`endif
        begin_op(8'h7F, 8'h80, 1'b0);
        wait_bits(WIDTH - 1);
        finish_op("7f_p_80", 8'hFF, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
        check("7f_p_80_ovf", 32'(ovf), 32'd0);
`endif
        tick();
        check("final_done", 32'(done), 32'd0);
        check("final_sum_hold", 32'(sum), 32'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
